ascon_host_if: RTL

Byte-serial host front end for the `ascon` core. It accepts commands and data bytes from the chip's 8-bit input port and assembles them into the core's 128-bit operand registers `reg0_128b`, `reg1_128b` and `reg2_128b`. It issues the one-cycle `operation_ready` start with `operation_mode`, then streams the 320-bit permutation state (`S_0_reg`…`S_4_reg`) back out one byte at a time. It is the writer for everything `ascon` reads and the reader for everything `ascon` produces.

---
 rtl/ascon_host_if.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ascon_host_if.sv
// Byte-serial host front end for the ascon core: loads the 128-bit operand registers,
// issues the start strobe, and streams the 320-bit permutation state back out MSB first.
module ascon_host_if #(
    parameter int unsigned RUN_CYCLES = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [7:0]   out_data,
    input  logic         out_ready,
    output logic         busy,
    output logic [127:0] reg0_128b,
    output logic [127:0] reg1_128b,
    output logic [127:0] reg2_128b,
    output logic [2:0]   operation_mode,
    output logic         operation_ready,
    input  logic [63:0]  S_0_reg,
    input  logic [63:0]  S_1_reg,
    input  logic [63:0]  S_2_reg,
    input  logic [63:0]  S_3_reg,
    input  logic [63:0]  S_4_reg
);

    typedef enum logic [1:0] {ST_CMD, ST_LOAD, ST_RUN, ST_READ} state_t;

    localparam logic [5:0] RUN_INIT = 6'(RUN_CYCLES);

    state_t       state_q, state_d;
    logic [127:0] reg0_q, reg0_d, reg1_q, reg1_d, reg2_q, reg2_d;
    logic [2:0]   mode_q, mode_d;
    logic         opr_q, opr_d;
    logic [5:0]   run_cnt_q, run_cnt_d;
    logic [3:0]   byte_cnt_q, byte_cnt_d;
    logic [1:0]   sel_q, sel_d;
    logic [2:0]   word_q, word_d;

    logic         in_fire, out_fire;
    logic [63:0]  rd_word, rd_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_CMD;
            reg0_q     <= '0;
            reg1_q     <= '0;
            reg2_q     <= '0;
            mode_q     <= '0;
            opr_q      <= 1'b0;
            run_cnt_q  <= '0;
            byte_cnt_q <= '0;
            sel_q      <= '0;
            word_q     <= '0;
        end else begin
            state_q    <= state_d;
            reg0_q     <= reg0_d;
            reg1_q     <= reg1_d;
            reg2_q     <= reg2_d;
            mode_q     <= mode_d;
            opr_q      <= opr_d;
            run_cnt_q  <= run_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            sel_q      <= sel_d;
            word_q     <= word_d;
        end
    end

    // Handshake readiness depends only on registered state, never on the opposite valid/ready.
    assign in_ready  = (state_q == ST_CMD) || (state_q == ST_LOAD);
    assign out_valid = (state_q == ST_READ);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        state_d    = state_q;
        reg0_d     = reg0_q;
        reg1_d     = reg1_q;
        reg2_d     = reg2_q;
        mode_d     = mode_q;
        opr_d      = 1'b0;
        run_cnt_d  = run_cnt_q;
        byte_cnt_d = byte_cnt_q;
        sel_d      = sel_q;
        word_d     = word_q;
        case (state_q)
            ST_CMD: begin
                if (in_fire) begin
                    case (in_data[7:6])
                        2'b01: begin
                            if (in_data[1:0] != 2'd3) begin
                                sel_d      = in_data[1:0];
                                byte_cnt_d = '0;
                                state_d    = ST_LOAD;
                            end
                        end
                        2'b10: begin
                            mode_d    = in_data[2:0];
                            opr_d     = 1'b1;
                            run_cnt_d = RUN_INIT;
                            state_d   = ST_RUN;
                        end
                        2'b11: begin
                            if (in_data[2:0] <= 3'd4) begin
                                word_d     = in_data[2:0];
                                byte_cnt_d = '0;
                                state_d    = ST_READ;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_LOAD: begin
                if (in_fire) begin
                    case (sel_q)
                        2'd0:    reg0_d = {reg0_q[119:0], in_data};
                        2'd1:    reg1_d = {reg1_q[119:0], in_data};
                        2'd2:    reg2_d = {reg2_q[119:0], in_data};
                        default: ;
                    endcase
                    byte_cnt_d = byte_cnt_q + 4'd1;
                    if (byte_cnt_q == 4'd15)
                        state_d = ST_CMD;
                end
            end
            ST_RUN: begin
                // Leaving on the last busy cycle puts in_ready back up exactly when busy drops.
                if (run_cnt_q != '0)
                    run_cnt_d = run_cnt_q - 6'd1;
                if (run_cnt_q <= 6'd1)
                    state_d = ST_CMD;
            end
            ST_READ: begin
                if (out_fire) begin
                    byte_cnt_d = {1'b0, byte_cnt_q[2:0] + 3'd1};
                    if (byte_cnt_q[2:0] == 3'd7) begin
                        word_d = word_q + 3'd1;
                        if (word_q == 3'd4)
                            state_d = ST_CMD;
                    end
                end
            end
            default: state_d = ST_CMD;
        endcase
    end

    always_comb begin
        case (word_q)
            3'd0:    rd_word = S_0_reg;
            3'd1:    rd_word = S_1_reg;
            3'd2:    rd_word = S_2_reg;
            3'd3:    rd_word = S_3_reg;
            3'd4:    rd_word = S_4_reg;
            default: rd_word = '0;
        endcase
        rd_shift = rd_word << {byte_cnt_q[2:0], 3'b000};
        out_data = (state_q == ST_READ) ? rd_shift[63:56] : 8'h00;
    end

    assign busy            = (run_cnt_q != '0);
    assign reg0_128b       = reg0_q;
    assign reg1_128b       = reg1_q;
    assign reg2_128b       = reg2_q;
    assign operation_mode  = mode_q;
    assign operation_ready = opr_q;

endmodule
